// File: rtl/ni_local_port_if.sv
// Local-port NI signal bundle: PE word streams plus
// the credit-based flit link to the router L port.
interface ni_local_port_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_ADD      = 2
);
  logic                  pe_tx_valid;
  logic                  pe_tx_ready;
  logic [DATA_WIDTH-1:0] pe_tx_data;
  logic [N_ADD-1:0]      pe_dst_x;
  logic [N_ADD-1:0]      pe_dst_y;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_val;
  logic                  tx_ret;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_val;
  logic                  rx_ret;
  logic                  pe_rx_valid;
  logic                  pe_rx_ready;
  logic [DATA_WIDTH-1:0] pe_rx_data;
  logic                  pe_rx_sop;

  modport slave (
    input  pe_tx_valid, pe_tx_data,
    input  pe_dst_x, pe_dst_y,
    input  tx_ret, rx_data, rx_val,
    input  pe_rx_ready,
    output pe_tx_ready, tx_data, tx_val,
    output rx_ret, pe_rx_valid,
    output pe_rx_data, pe_rx_sop
  );

  modport master (
    output pe_tx_valid, pe_tx_data,
    output pe_dst_x, pe_dst_y,
    output tx_ret, rx_data, rx_val,
    output pe_rx_ready,
    input  pe_tx_ready, tx_data, tx_val,
    input  rx_ret, pe_rx_valid,
    input  pe_rx_data, pe_rx_sop
  );
endinterface

// File: rtl/ni_local_port.sv
// Network interface between a PE and a router Local port:
// credit-based packet TX and header-stripping RX FIFO.
module ni_local_port #(
  parameter int DATA_WIDTH = 8,
  parameter int N_ADD      = 2,
  parameter int PKT_LEN    = 4,
  parameter int N_CREDIT   = 3,
  parameter int RX_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  ni_local_port_if.slave lp
);

  localparam int IW  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int CW  = $clog2(N_CREDIT + 1);
  localparam int RCW = $clog2(PKT_LEN + 1);
  localparam int PW  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int OW  = $clog2(RX_DEPTH + 1);

  localparam logic [IW-1:0]  IDX_LAST = IW'(PKT_LEN - 1);
  localparam logic [CW-1:0]  CMAX     = CW'(N_CREDIT);
  localparam logic [RCW-1:0] CNT_LAST = RCW'(PKT_LEN);
  localparam logic [PW-1:0]  PMAX     = PW'(RX_DEPTH - 1);
  localparam logic [OW-1:0]  OCC_MAX  = OW'(RX_DEPTH);

  typedef enum logic [1:0] {
    COLLECT,
    HEAD,
    BODY
  } tx_state_t;

  tx_state_t state, state_n;

  logic [DATA_WIDTH-1:0] tx_buf [PKT_LEN];
  logic [IW-1:0]         wr_idx, wr_idx_n;
  logic [IW-1:0]         rd_idx, rd_idx_n;
  logic [N_ADD-1:0]      dst_x, dst_y;
  logic [CW-1:0]         credit, credit_n;
  logic [DATA_WIDTH-1:0] hdr, flit_n;
  logic                  send, rdy, tx_fire;

  assign hdr            = DATA_WIDTH'({dst_x, dst_y});
  assign tx_fire        = lp.pe_tx_valid & rdy;
  assign lp.pe_tx_ready = rdy;

  always_comb begin
    state_n  = state;
    wr_idx_n = wr_idx;
    rd_idx_n = rd_idx;
    send     = 1'b0;
    flit_n   = '0;
    unique case (state)
      COLLECT: begin
        if (tx_fire) begin
          if (wr_idx == IDX_LAST) begin
            wr_idx_n = '0;
            state_n  = HEAD;
          end else begin
            wr_idx_n = wr_idx + 1'b1;
          end
        end
      end
      HEAD: begin
        if (credit != '0) begin
          send     = 1'b1;
          flit_n   = hdr;
          rd_idx_n = '0;
          state_n  = BODY;
        end
      end
      BODY: begin
        if (credit != '0) begin
          send   = 1'b1;
          flit_n = tx_buf[rd_idx];
          if (rd_idx == IDX_LAST) begin
            rd_idx_n = '0;
            state_n  = COLLECT;
          end else begin
            rd_idx_n = rd_idx + 1'b1;
          end
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  // A return that coincides with a send cancels out.
  always_comb begin
    credit_n = credit;
    if (send && !lp.tx_ret) begin
      credit_n = credit - 1'b1;
    end else if (!send && lp.tx_ret && credit != CMAX) begin
      credit_n = credit + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= COLLECT;
      wr_idx     <= '0;
      rd_idx     <= '0;
      credit     <= CMAX;
      rdy        <= 1'b0;
      dst_x      <= '0;
      dst_y      <= '0;
      lp.tx_val  <= 1'b0;
      lp.tx_data <= '0;
      for (int i = 0; i < PKT_LEN; i++) begin
        tx_buf[i] <= '0;
      end
    end else begin
      state      <= state_n;
      wr_idx     <= wr_idx_n;
      rd_idx     <= rd_idx_n;
      credit     <= credit_n;
      rdy        <= (state_n == COLLECT);
      lp.tx_val  <= send;
      lp.tx_data <= flit_n;
      if (tx_fire) begin
        tx_buf[wr_idx] <= lp.pe_tx_data;
        if (wr_idx == '0) begin
          dst_x <= lp.pe_dst_x;
          dst_y <= lp.pe_dst_y;
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] fifo_d [RX_DEPTH];
  logic                  fifo_s [RX_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [OW-1:0]         occ;
  logic [RCW-1:0]        rx_cnt;
  logic [1:0]            pend, pend_n;
  logic [2:0]            ret_sum;
  logic                  full, empty, pop;
  logic                  accept, hdr_in, wr;

  assign empty  = (occ == '0);
  assign full   = (occ == OCC_MAX);
  assign pop    = !empty & lp.pe_rx_ready;
  assign accept = lp.rx_val & (!full | pop);
  assign hdr_in = accept & (rx_cnt == '0);
  assign wr     = accept & (rx_cnt != '0);

  assign lp.pe_rx_valid = !empty;
  assign lp.pe_rx_data  = empty ? '0 : fifo_d[rptr];
  assign lp.pe_rx_sop   = !empty & fifo_s[rptr];

  // Header release and pop together: second pulse is deferred.
  always_comb begin
    ret_sum = {1'b0, pend} + {2'b00, hdr_in}
            + {2'b00, pop};
    pend_n  = '0;
    if (ret_sum != '0) begin
      pend_n = 2'(ret_sum - 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      rx_cnt    <= '0;
      pend      <= '0;
      lp.rx_ret <= 1'b0;
      for (int i = 0; i < RX_DEPTH; i++) begin
        fifo_d[i] <= '0;
        fifo_s[i] <= 1'b0;
      end
    end else begin
      pend      <= pend_n;
      lp.rx_ret <= (ret_sum != '0);
      if (accept) begin
        rx_cnt <= (rx_cnt == CNT_LAST) ? '0 : rx_cnt + 1'b1;
      end
      if (wr) begin
        fifo_d[wptr] <= lp.rx_data;
        fifo_s[wptr] <= (rx_cnt == RCW'(1));
        wptr <= (wptr == PMAX) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == PMAX) ? '0 : rptr + 1'b1;
      end
      unique case ({wr, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_local_port.sv
// Scoreboard bench for ni_local_port: TX flits and RX words
// are queued when driven and compared as the DUT emits them.
module tb_ni_local_port;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  ni_local_port_if #(.DATA_WIDTH(8), .N_ADD(2)) lp ();

  ni_local_port #(
    .DATA_WIDTH(8),
    .N_ADD(2),
    .PKT_LEN(4),
    .N_CREDIT(3),
    .RX_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lp(lp)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] tx_q [$];
  logic [8:0] rx_q [$];

  int tx_cnt    = 0;
  int rxr_cnt   = 0;
  int rets_done = 0;
  int rets_prev = 0;
  int tx_base   = 0;
  int ret_base  = 0;
  bit cr_chk    = 1'b1;
  bit auto_ret  = 1'b0;
  bit man_ret   = 1'b0;
  logic [1:0] echo = 2'b00;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Router model: echoes a credit two cycles after each flit.
  always @(posedge clk) begin
    #2;
    rets_prev = rets_done;
    rets_done += int'(lp.tx_ret);
    echo      = {echo[0], lp.tx_val & auto_ret};
    lp.tx_ret = echo[1] | man_ret;
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      if (lp.tx_val) begin
        tx_cnt++;
        if (tx_q.size() == 0) begin
          check("tx_extra", 1, 0);
        end else begin
          check("tx_flit", lp.tx_data, tx_q.pop_front());
        end
        if (cr_chk) begin
          check("credit_bound",
                ((tx_cnt - tx_base) - (rets_prev - ret_base)) <= 3, 1);
        end
      end
      if (lp.rx_ret) rxr_cnt++;
      if (lp.pe_rx_valid && lp.pe_rx_ready) begin
        if (rx_q.size() == 0) begin
          check("rx_extra", 1, 0);
        end else begin
          e = rx_q.pop_front();
          check("rx_data", lp.pe_rx_data, e[7:0]);
          check("rx_sop", lp.pe_rx_sop, e[8]);
        end
      end
    end
  end

  task automatic send_pkt(input logic [1:0] x, input logic [1:0] y,
                          input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] w [4];
    int b;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    tx_q.push_back({4'h0, x, y});
    for (int i = 0; i < 4; i++) tx_q.push_back(w[i]);
    for (int i = 0; i < 4; i++) begin
      lp.pe_tx_valid = 1'b1;
      lp.pe_tx_data  = w[i];
      lp.pe_dst_x    = (i == 0) ? x : ~x;
      lp.pe_dst_y    = (i == 0) ? y : ~y;
      b = 0;
      while (!lp.pe_tx_ready && b < 200) begin
        tick();
        b++;
      end
      if (!lp.pe_tx_ready) check("tx_ready_timeout", 0, 1);
      tick();
    end
    lp.pe_tx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int b = 0;
    while (tx_cnt < n && b < budget) begin
      tick();
      b++;
    end
    if (tx_cnt < n) check("tx_timeout", tx_cnt, n);
  endtask

  task automatic rx_send(input logic [7:0] d);
    lp.rx_val  = 1'b1;
    lp.rx_data = d;
    tick();
    lp.rx_val  = 1'b0;
  endtask

  initial begin
    int t0, r0, n;
    lp.pe_tx_valid = 1'b0;
    lp.pe_tx_data  = '0;
    lp.pe_dst_x    = '0;
    lp.pe_dst_y    = '0;
    lp.rx_val      = 1'b0;
    lp.rx_data     = '0;
    lp.pe_rx_ready = 1'b0;
    #12;
    check("rst_tx_val", lp.tx_val, 0);
    check("rst_tx_data", lp.tx_data, 0);
    check("rst_tx_ready", lp.pe_tx_ready, 0);
    check("rst_rx_ret", lp.rx_ret, 0);
    check("rst_rx_valid", lp.pe_rx_valid, 0);
    check("rst_rx_data", lp.pe_rx_data, 0);
    check("rst_rx_sop", lp.pe_rx_sop, 0);
    tick();
    rst = 1'b1;
    tick();
    check("tx_ready_after_rst", lp.pe_tx_ready, 1);

    // basic packet with credit echo
    auto_ret = 1'b1;
    send_pkt(2'd2, 2'd1, 8'h11, 8'h22, 8'h33, 8'h44);
    wait_tx(5, 40);
    repeat (6) tick();
    check("t1_flits", tx_cnt, 5);
    check("t1_q_empty", tx_q.size(), 0);

    // credit exhaustion
    auto_ret = 1'b0;
    t0 = tx_cnt;
    send_pkt(2'd1, 2'd3, 8'h5a, 8'ha5, 8'h3c, 8'hc3);
    repeat (10) tick();
    check("t2_stall_cnt", tx_cnt - t0, 3);
    check("t2_stall_val", lp.tx_val, 0);
    man_ret = 1'b1;
    tick();
    man_ret = 1'b0;
    check("t2_not_yet", lp.tx_val, 0);
    tick();
    check("t2_one_flit", lp.tx_val, 1);
    tick();
    check("t2_stall_again", lp.tx_val, 0);
    repeat (4) tick();
    check("t2_cnt4", tx_cnt - t0, 4);
    for (int i = 0; i < 4; i++) begin
      man_ret = 1'b1;
      tick();
      man_ret = 1'b0;
      tick();
    end
    repeat (4) tick();
    check("t2_cnt5", tx_cnt - t0, 5);

    // back-to-back packets, returns coincide with sends
    auto_ret = 1'b1;
    t0 = tx_cnt;
    send_pkt(2'd0, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04);
    send_pkt(2'd3, 2'd3, 8'hf1, 8'hf2, 8'hf3, 8'hf4);
    send_pkt(2'd1, 2'd2, 8'h70, 8'h71, 8'h72, 8'h73);
    wait_tx(t0 + 15, 100);
    repeat (6) tick();
    check("t5_flits", tx_cnt - t0, 15);
    check("t5_q_empty", tx_q.size(), 0);

    // RX streaming
    lp.pe_rx_ready = 1'b1;
    r0 = rxr_cnt;
    rx_q.push_back({1'b1, 8'ha1});
    rx_q.push_back({1'b0, 8'ha2});
    rx_q.push_back({1'b0, 8'ha3});
    rx_q.push_back({1'b0, 8'ha4});
    rx_send(8'h06);
    rx_send(8'ha1);
    rx_send(8'ha2);
    rx_send(8'ha3);
    rx_send(8'ha4);
    repeat (8) tick();
    check("t3_rets", rxr_cnt - r0, 5);
    check("t3_rx_q_empty", rx_q.size(), 0);

    // RX fill, drop, single pop, header+pop together
    lp.pe_rx_ready = 1'b0;
    r0 = rxr_cnt;
    rx_q.push_back({1'b1, 8'hb1});
    rx_q.push_back({1'b0, 8'hb2});
    rx_q.push_back({1'b0, 8'hb3});
    rx_q.push_back({1'b0, 8'hb4});
    rx_send(8'h05);
    rx_send(8'hb1);
    rx_send(8'hb2);
    rx_send(8'hb3);
    rx_send(8'hb4);
    repeat (3) tick();
    check("t4_full_valid", lp.pe_rx_valid, 1);
    check("t4_hdr_ret_only", rxr_cnt - r0, 1);
    rx_send(8'hee);
    repeat (3) tick();
    check("t4_drop_no_ret", rxr_cnt - r0, 1);
    lp.pe_rx_ready = 1'b1;
    tick();
    lp.pe_rx_ready = 1'b0;
    repeat (3) tick();
    check("t4_one_pop_ret", rxr_cnt - r0, 2);
    rx_q.push_back({1'b1, 8'hc1});
    rx_q.push_back({1'b0, 8'hc2});
    rx_q.push_back({1'b0, 8'hc3});
    rx_q.push_back({1'b0, 8'hc4});
    lp.pe_rx_ready = 1'b1;
    rx_send(8'h07);
    rx_send(8'hc1);
    rx_send(8'hc2);
    rx_send(8'hc3);
    rx_send(8'hc4);
    repeat (10) tick();
    check("t4_total_rets", rxr_cnt - r0, 10);
    check("t4_drained", lp.pe_rx_valid, 0);
    check("t4_rx_q_empty", rx_q.size(), 0);

    // reset in the middle of the body
    send_pkt(2'd3, 2'd2, 8'hd0, 8'hd1, 8'hd2, 8'hd3);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      tick();
      if (lp.tx_val) n++;
    end
    check("t6_reached_body", n, 3);
    cr_chk = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_rst_tx_val", lp.tx_val, 0);
    check("t6_rst_ready", lp.pe_tx_ready, 0);
    tx_q.delete();
    auto_ret = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) tick();
    tx_base  = tx_cnt;
    ret_base = rets_done;
    cr_chk   = 1'b1;
    send_pkt(2'd2, 2'd3, 8'he0, 8'he1, 8'he2, 8'he3);
    repeat (10) tick();
    check("t6_full_credit", tx_cnt - tx_base, 3);
    for (int i = 0; i < 5; i++) begin
      man_ret = 1'b1;
      tick();
      man_ret = 1'b0;
      tick();
    end
    repeat (4) tick();
    check("t6_all_flits", tx_cnt - tx_base, 5);
    check("t6_q_empty", tx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
